memory_stage_mc: RTL and testbench

- Parametrised successor of the pipeline MEM stage: decodes the instruction in MEM, accesses an internal word-organised data memory and returns load data to WB.
- Adds byte/halfword loads and stores with sign/zero extension, configurable depth and data width, and a multi-cycle access FSM with a stall handshake toward the hazard unit.
- Sits between the EX/MEM and MEM/WB pipeline registers.

---
 rtl/memory_stage_mc_pkg.sv | 68 ++++++
 rtl/memory_stage_mc_mem_byte_ext.sv | 32 +++
 rtl/memory_stage_mc.sv | 166 ++++++++++++++++
 tb/tb_memory_stage_mc.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_stage_mc_pkg.sv
// Shared definitions for the multi-cycle MEM stage: opcode constants,
// FSM state encodings, load/store decode types and the decode helper.
package memory_stage_mc_pkg;

  // Load/store opcodes found in Inst[31:26].
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SB  = 6'b101000;

  // Access FSM state encodings.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [2:0] {
    LD_NONE,
    LD_W,
    LD_H,
    LD_HU,
    LD_B,
    LD_BU
  } ld_type_e;

  typedef enum logic [1:0] {
    SZ_W,
    SZ_H,
    SZ_B
  } mem_size_e;

  typedef struct packed {
    logic      is_load;
    logic      is_store;
    ld_type_e  ld_type;
    mem_size_e size;
  } mem_op_t;

  // Opcode field of an instruction word.
  function automatic logic [5:0] opcode_of(input logic [31:0] inst);
    return inst[31:26];
  endfunction

  // Classify an opcode as load, store or non-memory and give its access size.
  function automatic mem_op_t decode_op(input logic [5:0] op);
    mem_op_t d;
    d.is_load  = 1'b0;
    d.is_store = 1'b0;
    d.ld_type  = LD_NONE;
    d.size     = SZ_W;
    case (op)
      OP_LW:  begin d.is_load  = 1'b1; d.ld_type = LD_W;  d.size = SZ_W; end
      OP_LH:  begin d.is_load  = 1'b1; d.ld_type = LD_H;  d.size = SZ_H; end
      OP_LHU: begin d.is_load  = 1'b1; d.ld_type = LD_HU; d.size = SZ_H; end
      OP_LB:  begin d.is_load  = 1'b1; d.ld_type = LD_B;  d.size = SZ_B; end
      OP_LBU: begin d.is_load  = 1'b1; d.ld_type = LD_BU; d.size = SZ_B; end
      OP_SW:  begin d.is_store = 1'b1; d.size = SZ_W; end
      OP_SH:  begin d.is_store = 1'b1; d.size = SZ_H; end
      OP_SB:  begin d.is_store = 1'b1; d.size = SZ_B; end
      default: ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/memory_stage_mc_mem_byte_ext.sv
// Load lane selection and sign/zero extension. Purely combinational:
// picks the byte or halfword addressed by addr_lo out of a memory word
// and extends it to 32 bits according to the load type.
module mem_byte_ext
  import memory_stage_mc_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  ld_type_e    ld_type,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Select the addressed lane and extend it.
  always_comb begin
    // NOTE: every variable assigned here gets a default first, so no path can leave it unassigned and infer a latch.
    result   = '0;
    byte_sel = word[{addr_lo, 3'b000} +: 8];
    half_sel = addr_lo[1] ? word[31:16] : word[15:0];
    case (ld_type)
      LD_W:    result = word;
      LD_H:    result = {{16{half_sel[15]}}, half_sel};
      LD_HU:   result = {16'h0000, half_sel};
      LD_B:    result = {{24{byte_sel[7]}}, byte_sel};
      LD_BU:   result = {24'h000000, byte_sel};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/memory_stage_mc.sv
// Multi-cycle pipeline MEM stage with an internal word-organised data
// memory, byte/halfword/word loads and stores, and a stall handshake.
// Optional feature macro: MEM_ALIGN_CHECK_EN (misaligned accesses raise
// exc, loads return 0 and stores are dropped; timing is unchanged).
module memory_stage_mc
  import memory_stage_mc_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned DEPTH_WORDS = 3072,
  parameter int unsigned LATENCY     = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       Inst,
  input  logic [31:0]       AO,
  input  logic [DATA_W-1:0] rt,
  output logic [31:0]       Inst_out,
  output logic [31:0]       AO_out,
  output logic [DATA_W-1:0] MO,
  output logic              stall,
  output logic              busy,
  output logic              exc,
  output logic              memory_write_enable_out
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam int unsigned CNT_W = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;

  logic [DATA_W-1:0] mem [DEPTH_WORDS];
  logic [1:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] rdata_q;

  mem_op_t           op;
  logic              is_mem;
  logic              misalign;
  logic [IDX_W-1:0]  idx_raw;
  logic [IDX_W-1:0]  idx;
  logic [3:0]        be;
  logic [DATA_W-1:0] wdata;
  logic              we;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] load_word;
  logic [31:0]       ext_result;

  assign Inst_out = Inst;
  assign AO_out   = AO;

  assign op     = decode_op(opcode_of(Inst));
  assign is_mem = op.is_load | op.is_store;

  // Word index wraps modulo the depth; the raw index is below twice the
  // depth, so one conditional subtract is enough.
  assign idx_raw = AO[2 +: IDX_W];
  assign idx     = ({1'b0, idx_raw} >= (IDX_W + 1)'(DEPTH_WORDS))
                 ? idx_raw - IDX_W'(DEPTH_WORDS) : idx_raw;

`ifdef MEM_ALIGN_CHECK_EN
  // Flag word accesses off a word boundary and halfword accesses on an odd byte.
  always_comb begin
    misalign = 1'b0;
    if (is_mem) begin
      case (op.size)
        SZ_W:    misalign = (AO[1:0] != 2'b00);
        SZ_H:    misalign = AO[0];
        default: misalign = 1'b0;
      endcase
    end
  end
`else
  assign misalign = 1'b0;
`endif

  assign exc = misalign;

  // Byte enables and lane-replicated store data.
  always_comb begin
    be    = 4'b0000;
    wdata = rt;
    if (op.is_store) begin
      case (op.size)
        SZ_W: be = 4'b1111;
        SZ_H: begin
          be    = AO[1] ? 4'b1100 : 4'b0011;
          wdata = {2{rt[15:0]}};
        end
        SZ_B: begin
          be    = 4'b0001 << AO[1:0];
          wdata = {4{rt[7:0]}};
        end
        default: be = 4'b0000;
      endcase
    end
  end

  // A store commits on the edge leaving DONE, or on the presenting edge when there is no latency.
  assign we = op.is_store && !misalign &&
              ((LATENCY == 0) || (state == ST_DONE));
  assign memory_write_enable_out = we;

  assign stall = (LATENCY > 0) &&
                 (((state == ST_IDLE) && is_mem) || (state == ST_BUSY));
  assign busy  = (state != ST_IDLE);

  // Access FSM. cnt holds the number of BUSY cycles still to run, so the
  // IDLE cycle plus the BUSY cycles stall for exactly LATENCY cycles.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      rdata_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if ((LATENCY > 0) && is_mem) begin
            if (LATENCY == 1) begin
              rdata_q <= rd_word;
              state   <= ST_DONE;
            end else begin
              cnt   <= CNT_W'(LATENCY - 1);
              state <= ST_BUSY;
            end
          end
        end
        ST_BUSY: begin
          if (cnt <= CNT_W'(1)) begin
            rdata_q <= rd_word;
            cnt     <= '0;
            state   <= ST_DONE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Data memory array with per-byte write enables.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: the memory is cleared on reset, which forces it into flops rather than a RAM macro; a reset mid-store drops the store.
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH_WORDS); i++) mem[i] <= '0;
    end else if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rd_word   = mem[idx];
  assign load_word = (LATENCY == 0) ? rd_word : rdata_q;

  mem_byte_ext u_ext (
    .word    (load_word),
    .addr_lo (AO[1:0]),
    .ld_type (op.ld_type),
    .result  (ext_result)
  );

  assign MO = (op.is_load && !misalign && ((LATENCY == 0) || (state == ST_DONE)))
            ? ext_result : '0;

endmodule

// File: tb/tb_memory_stage_mc.sv
// Scoreboard bench for memory_stage_mc (LATENCY=2). The driver issues
// directed memory ops and pushes hand-computed results; a monitor on the
// falling edge pops and compares whenever a memory op completes (stall=0).
module tb_memory_stage_mc;

  localparam logic [5:0] T_LW  = 6'b100011;
  localparam logic [5:0] T_LH  = 6'b100001;
  localparam logic [5:0] T_LHU = 6'b100101;
  localparam logic [5:0] T_LB  = 6'b100000;
  localparam logic [5:0] T_LBU = 6'b100100;
  localparam logic [5:0] T_SW  = 6'b101011;
  localparam logic [5:0] T_SH  = 6'b101001;
  localparam logic [5:0] T_SB  = 6'b101000;
  localparam logic [31:0] RTYPE_ADD = 32'h00221820;
  localparam int EXP_STALLS = 2;

  typedef struct {
    string       name;
    logic [31:0] mo;
    logic        we;
    logic        exc;
  } exp_t;

  logic        clk;
  logic        reset;
  logic [31:0] Inst;
  logic [31:0] AO;
  logic [31:0] rt;
  logic [31:0] Inst_out;
  logic [31:0] AO_out;
  logic [31:0] MO;
  logic        stall;
  logic        busy;
  logic        exc;
  logic        memory_write_enable_out;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  memory_stage_mc #(
    .DATA_W      (32),
    .DEPTH_WORDS (3072),
    .LATENCY     (2)
  ) dut (
    .clk                     (clk),
    .reset                   (reset),
    .Inst                    (Inst),
    .AO                      (AO),
    .rt                      (rt),
    .Inst_out                (Inst_out),
    .AO_out                  (AO_out),
    .MO                      (MO),
    .stall                   (stall),
    .busy                    (busy),
    .exc                     (exc),
    .memory_write_enable_out (memory_write_enable_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic tb_is_mem(input logic [31:0] inst);
    case (inst[31:26])
      T_LW, T_LH, T_LHU, T_LB, T_LBU, T_SW, T_SH, T_SB: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Issue one memory op, push its expected completion, hold until stall drops.
  task automatic mem_op(input string name, input logic [5:0] opc, input logic [31:0] ao,
                        input logic [31:0] data, input logic [31:0] exp_mo,
                        input logic exp_we, input logic exp_exc);
    exp_t e;
    bit   done;
    int   n;
    @(posedge clk);
    #1;
    Inst = {opc, 26'h0};
    AO   = ao;
    rt   = data;
    e.name = name;
    e.mo   = exp_mo;
    e.we   = exp_we;
    e.exc  = exp_exc;
    sb_q.push_back(e);
    done = 1'b0;
    n    = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      if (!stall) done = 1'b1;
      n++;
    end
    if (!done) check({name, "_timeout"}, 32'(done), 32'd1);
  endtask

  // Present a non-memory instruction for a number of cycles.
  task automatic rtype_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      Inst = RTYPE_ADD;
      AO   = $urandom;
      rt   = $urandom;
    end
  endtask

  // Monitor: pass-through every cycle, stall bookkeeping, scoreboard pops.
  int          stall_run = 0;
  logic [31:0] prev_inst;
  logic [31:0] prev_ao;
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      stall_run = 0;
    end else begin
      check("inst_passthru", Inst_out, Inst);
      check("ao_passthru", AO_out, AO);
      if (tb_is_mem(Inst)) begin
        if (stall_run > 0) begin
          check("hold_inst", Inst, prev_inst);
          check("hold_ao", AO, prev_ao);
        end
        if (stall) begin
          stall_run++;
          check("we_during_stall", 32'(memory_write_enable_out), 32'd0);
          check("busy_during_stall", 32'(busy), 32'(stall_run > 1));
          prev_inst = Inst;
          prev_ao   = AO;
        end else if (sb_q.size() == 0) begin
          check("unexpected_completion", 32'(sb_q.size()), 32'd1);
        end else begin
          e = sb_q.pop_front();
          check({e.name, "_mo"}, MO, e.mo);
          check({e.name, "_we"}, 32'(memory_write_enable_out), 32'(e.we));
          check({e.name, "_exc"}, 32'(exc), 32'(e.exc));
          check({e.name, "_stall_cycles"}, 32'(stall_run), 32'(EXP_STALLS));
          check({e.name, "_busy_done"}, 32'(busy), 32'd1);
          stall_run = 0;
        end
      end else begin
        check("nonmem_stall", 32'(stall), 32'd0);
        check("nonmem_we", 32'(memory_write_enable_out), 32'd0);
        check("nonmem_run", 32'(stall_run), 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    Inst  = 32'h0;
    AO    = 32'h0;
    rt    = 32'h0;
    repeat (3) @(negedge clk);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_exc", 32'(exc), 32'd0);
    check("rst_we", 32'(memory_write_enable_out), 32'd0);
    check("rst_mo", MO, 32'h0);
    reset = 1'b1;

    // Word store then load.
    mem_op("sw_10",  T_SW,  32'h10, 32'hDEADBEEF, 32'h0,        1'b1, 1'b0);
    mem_op("lw_10",  T_LW,  32'h10, 32'h0,        32'hDEADBEEF, 1'b0, 1'b0);
    // Byte store into lane 3 and signed/unsigned byte loads.
    mem_op("sb_13",  T_SB,  32'h13, 32'h00000080, 32'h0,        1'b1, 1'b0);
    mem_op("lb_13",  T_LB,  32'h13, 32'h0,        32'hFFFFFF80, 1'b0, 1'b0);
    mem_op("lbu_13", T_LBU, 32'h13, 32'h0,        32'h00000080, 1'b0, 1'b0);
    mem_op("lw_10b", T_LW,  32'h10, 32'h0,        32'h80ADBEEF, 1'b0, 1'b0);
    // Upper halfword store and halfword loads.
    mem_op("sh_22",  T_SH,  32'h22, 32'h00008001, 32'h0,        1'b1, 1'b0);
    mem_op("lh_22",  T_LH,  32'h22, 32'h0,        32'hFFFF8001, 1'b0, 1'b0);
    mem_op("lhu_22", T_LHU, 32'h22, 32'h0,        32'h00008001, 1'b0, 1'b0);
    mem_op("lw_20",  T_LW,  32'h20, 32'h0,        32'h80010000, 1'b0, 1'b0);

    // R-type stream interleaved with loads.
    rtype_cycles(4);
    mem_op("lw_10c", T_LW,  32'h10, 32'h0,        32'h80ADBEEF, 1'b0, 1'b0);
    rtype_cycles(3);
    mem_op("lb_11",  T_LB,  32'h11, 32'h0,        32'hFFFFFFBE, 1'b0, 1'b0);
    rtype_cycles(2);

    // Index wrap: word 3072 aliases word 0; positive byte/half extension.
    mem_op("sw_wrap", T_SW, 32'h3000, 32'h12345678, 32'h0,      1'b1, 1'b0);
    mem_op("lw_0",   T_LW,  32'h0,  32'h0,        32'h12345678, 1'b0, 1'b0);
    mem_op("lb_01",  T_LB,  32'h1,  32'h0,        32'h00000056, 1'b0, 1'b0);
    mem_op("lh_02",  T_LH,  32'h2,  32'h0,        32'h00001234, 1'b0, 1'b0);

    // Alignment behaviour depends on the optional check.
    mem_op("sw_30",  T_SW,  32'h30, 32'h11223344, 32'h0,        1'b1, 1'b0);
`ifdef MEM_ALIGN_CHECK_EN
    mem_op("sw_31",  T_SW,  32'h31, 32'hAABBCCDD, 32'h0,        1'b0, 1'b1);
    mem_op("lw_30",  T_LW,  32'h30, 32'h0,        32'h11223344, 1'b0, 1'b0);
    mem_op("lh_23",  T_LH,  32'h23, 32'h0,        32'h0,        1'b0, 1'b1);
`else
    mem_op("sw_31",  T_SW,  32'h31, 32'hAABBCCDD, 32'h0,        1'b1, 1'b0);
    mem_op("lw_30",  T_LW,  32'h30, 32'h0,        32'hAABBCCDD, 1'b0, 1'b0);
    mem_op("lh_23",  T_LH,  32'h23, 32'h0,        32'hFFFF8001, 1'b0, 1'b0);
`endif

    // Reset while an sw is in BUSY: store dropped, memory cleared.
    @(posedge clk);
    #1;
    Inst = {T_SW, 26'h0};
    AO   = 32'h40;
    rt   = 32'hCAFEF00D;
    @(posedge clk);
    #1;
    check("busy_before_reset", 32'(busy), 32'd1);
    reset = 1'b0;
    Inst  = 32'h0;
    AO    = 32'h0;
    rt    = 32'h0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_stall", 32'(stall), 32'd0);
    check("midrst_we", 32'(memory_write_enable_out), 32'd0);
    check("midrst_mo", MO, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    mem_op("lw_40_after_rst", T_LW, 32'h40, 32'h0, 32'h0, 1'b0, 1'b0);
    mem_op("lw_10_after_rst", T_LW, 32'h10, 32'h0, 32'h0, 1'b0, 1'b0);

    @(posedge clk);
    #1;
    Inst = 32'h0;
    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
